// File: rtl/mc_core_pkg.sv
// Shared definitions for the parametrised multicycle MIPS-subset core:
// FSM state encoding, opcode/funct constants, ALU control encodings and the
// funct decoder used by the EXECUTE state.
package mc_core_pkg;

  typedef enum logic [3:0] {
    ST_FETCH,
    ST_DECODE,
    ST_MEMADR,
    ST_MEMREAD,
    ST_MEMWB,
    ST_MEMWRITE,
    ST_EXECUTE,
    ST_ALUWB,
    ST_BRANCH,
    ST_ADDIEX,
    ST_ADDIWB,
    ST_JUMP,
    ST_HALT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Returns {valid, alu_ctl}; valid=0 marks an unsupported funct.
  function automatic logic [3:0] funct_decode(input logic [5:0] funct);
    case (funct)
      FN_ADD:  return {1'b1, ALU_ADD};
      FN_SUB:  return {1'b1, ALU_SUB};
      FN_AND:  return {1'b1, ALU_AND};
      FN_OR:   return {1'b1, ALU_OR};
      FN_SLT:  return {1'b1, ALU_SLT};
      default: return {1'b0, ALU_ADD};
    endcase
  endfunction

endpackage

// File: rtl/mc_core_param_regfile.sv
// Register file for mc_core_param: 2**REG_AW registers of XLEN bits,
// two asynchronous read ports, one synchronous write port, register 0
// hardwired to zero.
module mc_regfile #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] ra2,
  output logic [XLEN-1:0]   rd1,
  output logic [XLEN-1:0]   rd2,
  input  logic              we,
  input  logic [REG_AW-1:0] wa,
  input  logic [XLEN-1:0]   wd
);

  localparam int unsigned NREG = 2 ** REG_AW;

  logic [XLEN-1:0] regs [NREG];

  // Write port; writes to register 0 are dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (wa != '0)) begin
      regs[wa] <= wd;
    end
  end

  // Read ports return the pre-write value; register 0 always reads zero.
  always_comb begin
    rd1 = (ra1 == '0) ? '0 : regs[ra1];
    rd2 = (ra2 == '0) ? '0 : regs[ra2];
  end

endmodule

// File: rtl/mc_core_param.sv
// Parametrised multicycle MIPS-subset core (lw, sw, add/sub/and/or/slt, beq,
// addi, j) with a req/ready memory handshake and a terminal HALT state for
// illegal opcodes/functs.
// Optional feature macro: MC_CORE_BNE_EN -- when defined, opcode 6'h05 (bne)
// is executed as a branch on A != B; otherwise it halts the core.
module mc_core_param #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     REG_AW   = 5,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic            halted,
  output logic [XLEN-1:0] pc_dbg
);

  import mc_core_pkg::*;

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  state_t            state, state_next;
  logic              run;
  logic [XLEN-1:0]   pc, a, b, alu_out, mdr;
  logic [31:0]       ir;

  logic [5:0]        op, funct;
  logic [REG_AW-1:0] rs, rt, rd;
  logic [XLEN-1:0]   sext;

  logic              alu_valid;
  logic [2:0]        alu_ctl;
  logic [XLEN-1:0]   alu_res;
  logic              br_take;
  logic              mem_fire;

  logic              rf_we;
  logic [REG_AW-1:0] rf_wa;
  logic [XLEN-1:0]   rf_wd, rf_rd1, rf_rd2;

  assign op     = ir[31:26];
  assign funct  = ir[5:0];
  assign rs     = ir[21 +: REG_AW];
  assign rt     = ir[16 +: REG_AW];
  assign rd     = ir[11 +: REG_AW];
  assign sext   = {{(XLEN-16){ir[15]}}, ir[15:0]};
  assign pc_dbg = pc;

  mc_regfile #(
    .XLEN   (XLEN),
    .REG_AW (REG_AW)
  ) u_regfile (
    .clk     (clk),
    .reset_n (reset_n),
    .ra1     (rs),
    .ra2     (rt),
    .rd1     (rf_rd1),
    .rd2     (rf_rd2),
    .we      (rf_we),
    .wa      (rf_wa),
    .wd      (rf_wd)
  );

  // ALU for R-type operations, controlled by the funct field.
  always_comb begin
    {alu_valid, alu_ctl} = funct_decode(funct);
    alu_res = a + b;
    case (alu_ctl)
      ALU_AND: alu_res = a & b;
      ALU_OR:  alu_res = a | b;
      ALU_SUB: alu_res = a - b;
      ALU_SLT: alu_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      default: alu_res = a + b;
    endcase
  end

  // Branch condition: equality for beq, inequality for bne when enabled.
  always_comb begin
    br_take = (a == b);
`ifdef MC_CORE_BNE_EN
    if (op == OP_BNE) begin
      br_take = (a != b);
    end
`endif
  end

  // State register; run holds off the first fetch request until the first
  // edge after reset release, so mem_req stays low throughout reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_FETCH;
      run   <= 1'b0;
    end else begin
      state <= state_next;
      run   <= 1'b1;
    end
  end

  // Next-state logic, memory interface and register-file write control.
  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = alu_out;
    mem_wdata  = b;
    halted     = 1'b0;
    rf_we      = 1'b0;
    rf_wa      = rt;
    rf_wd      = alu_out;

    case (state)
      ST_FETCH: begin
        mem_req  = run;
        mem_addr = pc;
      end
      ST_MEMREAD:  mem_req = 1'b1;
      ST_MEMWRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
      end
      ST_MEMWB: begin
        rf_we = 1'b1;
        rf_wd = mdr;
      end
      ST_ALUWB: begin
        rf_we = 1'b1;
        rf_wa = rd;
      end
      ST_ADDIWB: rf_we  = 1'b1;
      ST_HALT:   halted = 1'b1;
      default: ;
    endcase

    mem_fire = mem_req && mem_ready;

    case (state)
      ST_FETCH:    if (mem_fire) state_next = ST_DECODE;
      ST_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = ST_MEMADR;
          OP_RTYPE:     state_next = ST_EXECUTE;
          OP_BEQ:       state_next = ST_BRANCH;
`ifdef MC_CORE_BNE_EN
          OP_BNE:       state_next = ST_BRANCH;
`endif
          OP_ADDI:      state_next = ST_ADDIEX;
          OP_J:         state_next = ST_JUMP;
          default:      state_next = ST_HALT;
        endcase
      end
      ST_MEMADR:   state_next = (op == OP_LW) ? ST_MEMREAD : ST_MEMWRITE;
      ST_MEMREAD:  if (mem_fire) state_next = ST_MEMWB;
      ST_MEMWB:    state_next = ST_FETCH;
      ST_MEMWRITE: if (mem_fire) state_next = ST_FETCH;
      ST_EXECUTE:  state_next = alu_valid ? ST_ALUWB : ST_HALT;
      ST_ALUWB:    state_next = ST_FETCH;
      ST_BRANCH:   state_next = ST_FETCH;
      ST_ADDIEX:   state_next = ST_ADDIWB;
      ST_ADDIWB:   state_next = ST_FETCH;
      ST_JUMP:     state_next = ST_FETCH;
      ST_HALT:     state_next = ST_HALT;
      default:     state_next = ST_HALT;
    endcase
  end

  // Datapath registers: PC, IR, operand latches, ALU result and memory data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc      <= RESET_PC;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
      mdr     <= '0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (mem_fire) begin
            ir <= mem_rdata[31:0];
            pc <= pc + PC_STEP;
          end
        end
        ST_DECODE: begin
          a       <= rf_rd1;
          b       <= rf_rd2;
          alu_out <= pc + (sext << 2);
        end
        ST_MEMADR:  alu_out <= a + sext;
        ST_MEMREAD: if (mem_fire) mdr <= mem_rdata;
        ST_EXECUTE: alu_out <= alu_res;
        ST_BRANCH:  if (br_take) pc <= alu_out;
        ST_ADDIEX:  alu_out <= a + sext;
        ST_JUMP:    pc <= {pc[XLEN-1:28], ir[25:0], 2'b00};
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mc_core_param.md
Name: mc_core_param

Overview:
- Parametrised multicycle MIPS-subset core: datapath plus integrated Moore control FSM in one block.
- Generalised successor of the fixed 32-bit multicycle datapath:
  - configurable data width, register count and reset vector;
  - variable-latency memory handshake (req/ready) instead of single-cycle memory;
  - halt state for illegal opcodes.
- Sits between the top level and a unified instruction/data memory.

Parameters:
- XLEN, 32, data/address width; legal values 32 or 64. Instructions are always 32 bits, taken from mem_rdata[31:0].
- REG_AW, 5, register index width. Register count = 2**REG_AW. Register fields use their low REG_AW bits.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- mem_req  output  1  memory transaction request
- mem_we  output  1  1 = write, 0 = read; valid while mem_req is high
- mem_addr  output  XLEN  byte address
- mem_wdata  output  XLEN  write data
- mem_rdata  input  XLEN  read data; valid in the cycle mem_ready is high
- mem_ready  input  1  transaction completes on any clk edge where mem_req && mem_ready
- halted  output  1  core stopped on an illegal opcode
- pc_dbg  output  XLEN  current PC

Behaviour:
- Reset (asynchronous, reset_n=0):
  - PC=RESET_PC; state=FETCH; IR=0; A, B, ALUOut and data register = 0; all registers = 0.
  - mem_req=0, mem_we=0, halted=0.
  - mem_req drops immediately even mid-transaction; the pending access is abandoned.
  - Fetch starts on the first edge after deassertion.
- Outputs: mem_req, mem_we, mem_addr and halted decode only from registered state. mem_addr/mem_wdata/mem_we stay stable while mem_req=1 and ready=0.
- Supported instructions: lw, sw, R-type add/sub/and/or/slt, beq, addi, j.
- States and transitions:
  - FETCH: mem_req=1, addr=PC. Stay until mem_ready. On ready: IR<=rdata[31:0], PC<=PC+4 → DECODE.
  - DECODE: A<=R[rs], B<=R[rt], ALUOut<=PC+(signext(imm)<<2).
    - lw/sw → MEMADR; R-type → EXECUTE; beq → BRANCH; addi → ADDIEX; j → JUMP.
    - Any other opcode → HALT.
  - MEMADR: ALUOut<=A+signext(imm). lw → MEMREAD; sw → MEMWRITE.
  - MEMREAD: req=1, we=0, addr=ALUOut. Wait for ready, then data<=rdata → MEMWB.
  - MEMWB: R[rt]<=data → FETCH.
  - MEMWRITE: req=1, we=1, addr=ALUOut, wdata=B. Wait for ready → FETCH.
  - EXECUTE: ALUOut<=A op B per funct. Unknown funct → HALT. Otherwise → ALUWB.
  - ALUWB: R[rd]<=ALUOut → FETCH.
  - BRANCH: if A==B, PC<=ALUOut → FETCH.
  - ADDIEX: ALUOut<=A+signext(imm) → ADDIWB.
  - ADDIWB: R[rt]<=ALUOut → FETCH.
  - JUMP: PC<={PC[XLEN-1:28], instr[25:0], 2'b00} → FETCH.
  - HALT: terminal state; halted=1, no memory requests; left only by reset.
- Arithmetic rules:
  - Sign extension is to XLEN.
  - All adds wrap modulo 2**XLEN.
  - slt is a signed compare producing 0/1.
- Register rules:
  - R[0] reads 0; writes to it are ignored.
  - Register writes occur on the edge leaving the writeback state.
  - Reads return the pre-write value (no same-cycle bypass is needed, since the core is multicycle).
- Latency: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles, plus one cycle per mem_ready=0 wait cycle.

Optional Feature:
- MC_CORE_BNE_EN: when defined, opcode 6'h05 (bne) decodes to BRANCH with the inverted compare (branch taken if A!=B).
- When undefined, 6'h05 is illegal and the core goes to HALT.

Decomposition:
- Package mc_core_pkg holds:
  - state enum (FETCH … HALT);
  - opcode constants (OP_RTYPE 0, OP_LW 23h, OP_SW 2Bh, OP_BEQ 04h, OP_BNE 05h, OP_ADDI 08h, OP_J 02h);
  - funct constants;
  - 3-bit ALU control encodings.
- One natural sub-module: mc_regfile (parametrised by XLEN/REG_AW, two async reads, one sync write, asynchronous reset, r0 hardwired to 0).

Test Plan:
- Reset mid-fetch: memory ready=0, deassert reset_n while mem_req=1 → mem_req=0 at once, pc_dbg=RESET_PC. After release, fetch is re-issued at RESET_PC.
- addi $1,$0,5 then addi $2,$0,-3 then add $3,$1,$2 (zero-wait memory) → R3=2, PC=12 after 12 cycles.
- sw $3,8($0) then lw $4,8($0), with ready delayed 3 cycles on each access → write seen at addr 8 with data 2; R4=2; addr/wdata stable during waits.
- beq $1,$1,-1 → PC returns to the beq address. beq $1,$2,+4 → not taken, PC+4.
- j 0x40 → PC=0x100. Opcode 3Fh → halted=1 and mem_req stays 0 for 20 cycles.
- XLEN=64, REG_AW=3: addi $9,$0,-1 writes R1 (index 9 & 7 = 1) = 64'hFFFF_FFFF_FFFF_FFFF. With MC_CORE_BNE_EN, bne $1,$0 is taken; without it, the core halts.
